fpsu_issue_ctl: RTL and testbench
=================================

FPSU_ISSUE_CTL -- requirements
Module: fpsu_issue_ctl

Interface
REQ-001 Parameter DEPTH, default 8; in-flight op capacity, power of two, 2..16.
REQ-002 Parameter WDOG_CYC, default 255; watchdog limit in cycles, used only when FPSU_ISSUE_WDOG_EN is defined.
REQ-003 clk  input  1  single clock; all state rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_vld/in_rdy  input/output  1/1  op handshake from scheduler.
REQ-006 in_A, in_B  input  68 each  operands.
REQ-007 in_op  input  13  opcode; in_en  input  4  lane enables; in_rob  input  9  ROB id.
REQ-008 flush  input  1  pipeline flush.
REQ-009 u_A, u_B  output  68  operands to FP unit; u_op  output  13; u_en  output  4.
REQ-010 u_ret  input  14  completion word, bits [4:0] exception flags, [13:5] opaque; u_ret_en  input  1  completion strobe.
REQ-011 cmp_vld  output  1; cmp_rob  output  9; cmp_ret  output  14  completion to ROB.
REQ-012 fflags  output  5  sticky exception flags; busy  output  1  count+drain nonzero.
REQ-013 err_orphan  output  1  sticky, u_ret_en with nothing outstanding; wdog_err  output  1  sticky watchdog.

Function
REQ-014 Accept when in_vld&in_rdy; in_rdy=(count+drain<DEPTH)&~flush, combinational.
REQ-015 An op accepted in cycle N drives u_A/u_B/u_op/u_en registered in N+1; u_en=0 every cycle with no accept; u_A/u_B/u_op hold their last values.
REQ-016 An accepted op pushes in_rob into an in-order tag FIFO at the accept edge; count increments.
REQ-017 u_ret_en with drain=0 and count>0 pops the head; cmp_vld=1, cmp_rob=head, cmp_ret=u_ret, all registered, one cycle after u_ret_en.
REQ-018 Push and pop in the same cycle leave count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-019 Each popped completion ORs u_ret[4:0] into fflags.
REQ-020 On flush: FIFO is emptied (count=0) and drain is loaded with the count remaining after any same-cycle pop; no cmp_vld for the popped entry.
REQ-021 A u_ret_en coincident with flush is consumed by the flush: it decrements the pre-flush count and produces no cmp_vld.
REQ-022 u_ret_en with drain>0 decrements drain; no cmp_vld, no fflags update.
REQ-023 u_ret_en with count=0 and drain=0 sets err_orphan; no other state changes.
REQ-024 A flush while drain>0 adds the current count to drain; saturation is impossible because count+drain<=DEPTH.
REQ-025 cmp_vld is never asserted in the cycle after a flush for a completion that arrived in the flush cycle.

Reset
REQ-026 On rst low, asynchronously: count=0, drain=0, pointers=0, u_en=0, u_A=u_B=0, u_op=0, cmp_vld=0, cmp_rob=0, cmp_ret=0, fflags=0, err_orphan=0, wdog_err=0, watchdog counter=0.
REQ-027 Reset asserted mid-operation discards all outstanding tags; a u_ret_en arriving after reset release with nothing outstanding sets err_orphan.
REQ-028 in_rdy is 0 while rst is low.

Configuration
REQ-029 Macro FPSU_ISSUE_WDOG_EN: when defined, a counter increments each cycle that busy=1 and u_ret_en=0, clears on u_ret_en or when busy=0, and sets wdog_err when it reaches WDOG_CYC.
REQ-030 When FPSU_ISSUE_WDOG_EN is undefined, the counter is absent and wdog_err is tied to 0.

Verification
REQ-031 Single op: in_rob=0x05 accepted at cycle 0, u_ret_en=1 with u_ret=0x0011 at cycle 4 -> u_en nonzero at cycle 1 only; at cycle 5 cmp_vld=1, cmp_rob=0x05, cmp_ret=0x0011; fflags=0x11.
REQ-032 Full: DEPTH=8, 8 accepts with no completions -> in_rdy=0; one u_ret_en -> in_rdy=1 next cycle; cmp_rob equals the first tag.
REQ-033 Flush: 3 outstanding, flush with a coincident u_ret_en -> drain=2; next 2 u_ret_en give no cmp_vld; the 3rd u_ret_en with nothing issued sets err_orphan.
REQ-034 Simultaneous ops: 4 outstanding, accept and u_ret_en in the same cycle -> count stays 4; pointers wrap correctly over 20 ops; completions emerge in issue order.
REQ-035 Watchdog (macro defined, WDOG_CYC=255): 1 op outstanding, no u_ret_en for 255 cycles -> wdog_err=1; macro undefined -> wdog_err stays 0.
REQ-036 Reset mid-flight: 5 outstanding, rst pulsed low -> all outputs at reset values immediately; busy=0 after release.

Source files
------------

// File: rtl/fpsu_issue_ctl.sv
// Issue/completion controller between the scheduler, one FP unit and the ROB.
// Optional watchdog is compiled in when FPSU_ISSUE_WDOG_EN is defined.
module fpsu_issue_ctl #(
    parameter int DEPTH    = 8,
    parameter int WDOG_CYC = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [67:0]  in_A,
    input  logic [67:0]  in_B,
    input  logic [12:0]  in_op,
    input  logic [3:0]   in_en,
    input  logic [8:0]   in_rob,
    input  logic         flush,
    output logic [67:0]  u_A,
    output logic [67:0]  u_B,
    output logic [12:0]  u_op,
    output logic [3:0]   u_en,
    input  logic [13:0]  u_ret,
    input  logic         u_ret_en,
    output logic         cmp_vld,
    output logic [8:0]   cmp_rob,
    output logic [13:0]  cmp_ret,
    output logic [4:0]   fflags,
    output logic         busy,
    output logic         err_orphan,
    output logic         wdog_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [CW-1:0] count, drain, count_nxt, drain_nxt;
    logic [CW-1:0] occupancy, count_after_pop, drain_after;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [8:0]    tag_mem [DEPTH];

    logic accept;
    logic ret_to_drain;
    logic ret_pop;
    logic ret_orphan;
    logic cmp_fire;

    assign occupancy = count + drain;
    assign busy      = (occupancy != '0);
    assign in_rdy    = rst & (occupancy < CW'(DEPTH)) & ~flush;
    assign accept    = in_vld & in_rdy;

    // Completions retire flushed (draining) ops first, since the FP unit returns in order.
    assign ret_to_drain = u_ret_en & (drain != '0);
    assign ret_pop      = u_ret_en & (drain == '0) & (count != '0);
    assign ret_orphan   = u_ret_en & (drain == '0) & (count == '0);
    assign cmp_fire     = ret_pop & ~flush;

    assign count_after_pop = count - CW'(ret_pop);
    assign drain_after     = drain - CW'(ret_to_drain);

    always_comb begin
        count_nxt  = count;
        drain_nxt  = drain_after;
        wr_ptr_nxt = wr_ptr + PW'(accept);
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            drain_nxt  = drain_after + count_after_pop;
            count_nxt  = '0;
            rd_ptr_nxt = wr_ptr;
        end else begin
            count_nxt  = count_after_pop + CW'(accept);
            rd_ptr_nxt = rd_ptr + PW'(ret_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            drain      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            u_A        <= '0;
            u_B        <= '0;
            u_op       <= '0;
            u_en       <= '0;
            cmp_vld    <= 1'b0;
            cmp_rob    <= '0;
            cmp_ret    <= '0;
            fflags     <= '0;
            err_orphan <= 1'b0;
        end else begin
            count   <= count_nxt;
            drain   <= drain_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            u_en    <= accept ? in_en : 4'd0;
            cmp_vld <= cmp_fire;
            if (accept) begin
                u_A  <= in_A;
                u_B  <= in_B;
                u_op <= in_op;
            end
            if (cmp_fire) begin
                cmp_rob <= tag_mem[rd_ptr];
                cmp_ret <= u_ret;
                fflags  <= fflags | u_ret[4:0];
            end
            if (ret_orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= in_rob;
        end
    end

`ifdef FPSU_ISSUE_WDOG_EN
    localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC + 1) : 1;
    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (u_ret_en || !busy) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WW'(WDOG_CYC)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpsu_issue_ctl.sv
// Directed bench for fpsu_issue_ctl: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_fpsu_issue_ctl;

    localparam int DEPTH = 8;
    localparam int WDOG  = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [67:0]  in_A = '0;
    logic [67:0]  in_B = '0;
    logic [12:0]  in_op = '0;
    logic [3:0]   in_en = '0;
    logic [8:0]   in_rob = '0;
    logic         flush = 1'b0;
    logic [67:0]  u_A, u_B;
    logic [12:0]  u_op;
    logic [3:0]   u_en;
    logic [13:0]  u_ret = '0;
    logic         u_ret_en = 1'b0;
    logic         cmp_vld;
    logic [8:0]   cmp_rob;
    logic [13:0]  cmp_ret;
    logic [4:0]   fflags;
    logic         busy;
    logic         err_orphan;
    logic         wdog_err;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    fpsu_issue_ctl #(.DEPTH(DEPTH), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_A(in_A), .in_B(in_B), .in_op(in_op), .in_en(in_en), .in_rob(in_rob),
        .flush(flush),
        .u_A(u_A), .u_B(u_B), .u_op(u_op), .u_en(u_en),
        .u_ret(u_ret), .u_ret_en(u_ret_en),
        .cmp_vld(cmp_vld), .cmp_rob(cmp_rob), .cmp_ret(cmp_ret),
        .fflags(fflags), .busy(busy),
        .err_orphan(err_orphan), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding tags in a queue, flushed ops tracked as a plain count.
    logic [8:0]  tag_q [$];
    int          m_drain   = 0;
    logic [67:0] m_uA      = '0;
    logic [67:0] m_uB      = '0;
    logic [12:0] m_op      = '0;
    logic [3:0]  m_en      = '0;
    bit          m_cmp_vld = 1'b0;
    logic [8:0]  m_cmp_rob = '0;
    logic [13:0] m_cmp_ret = '0;
    logic [4:0]  m_fflags  = '0;
    bit          m_orphan  = 1'b0;
    bit          m_wderr   = 1'b0;
    int          m_wd      = 0;
    int          m_occ;
    bit          m_acc;
    logic [8:0]  m_tag;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q.delete();
            m_drain = 0; m_uA = '0; m_uB = '0; m_op = '0; m_en = '0;
            m_cmp_vld = 1'b0; m_cmp_rob = '0; m_cmp_ret = '0; m_fflags = '0;
            m_orphan = 1'b0; m_wderr = 1'b0; m_wd = 0;
        end else begin
            m_occ = tag_q.size() + m_drain;
            m_acc = in_vld && (m_occ < DEPTH) && !flush;
`ifdef FPSU_ISSUE_WDOG_EN
            if (u_ret_en || m_occ == 0) m_wd = 0;
            else if (m_wd < WDOG) begin
                m_wd++;
                if (m_wd == WDOG) m_wderr = 1'b1;
            end
`endif
            m_en = m_acc ? in_en : 4'd0;
            if (m_acc) begin
                m_uA = in_A; m_uB = in_B; m_op = in_op;
            end
            m_cmp_vld = 1'b0;
            if (u_ret_en) begin
                if (m_drain > 0) m_drain--;
                else if (tag_q.size() > 0) begin
                    m_tag = tag_q.pop_front();
                    if (!flush) begin
                        m_cmp_vld = 1'b1;
                        m_cmp_rob = m_tag;
                        m_cmp_ret = u_ret;
                        m_fflags  = m_fflags | u_ret[4:0];
                    end
                end else m_orphan = 1'b1;
            end
            if (flush) begin
                m_drain += tag_q.size();
                tag_q.delete();
            end
            if (m_acc) tag_q.push_back(in_rob);
        end
    end

    task automatic check_output(input string name, input logic [67:0] act, input logic [67:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_output("in_rdy", 68'(in_rdy),
                         68'(rst && (tag_q.size() + m_drain < DEPTH) && !flush));
            check_output("busy", 68'(busy), 68'((tag_q.size() + m_drain) != 0));
            check_output("u_en", 68'(u_en), 68'(m_en));
            check_output("u_A", u_A, m_uA);
            check_output("u_B", u_B, m_uB);
            check_output("u_op", 68'(u_op), 68'(m_op));
            check_output("cmp_vld", 68'(cmp_vld), 68'(m_cmp_vld));
            if (m_cmp_vld) begin
                check_output("cmp_rob", 68'(cmp_rob), 68'(m_cmp_rob));
                check_output("cmp_ret", 68'(cmp_ret), 68'(m_cmp_ret));
            end
            check_output("fflags", 68'(fflags), 68'(m_fflags));
            check_output("err_orphan", 68'(err_orphan), 68'(m_orphan));
            check_output("wdog_err", 68'(wdog_err), 68'(m_wderr));
        end
    end

    task automatic apply_stimulus(input bit vld, input logic [8:0] rob, input bit ret_en,
                                  input logic [13:0] ret, input bit fl);
        in_vld   = vld;
        in_rob   = rob;
        in_en    = 4'($urandom_range(1, 15));
        in_A     = {$urandom, $urandom, 4'($urandom)};
        in_B     = {$urandom, $urandom, 4'($urandom)};
        in_op    = 13'($urandom);
        u_ret_en = ret_en;
        u_ret    = ret;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 9'h0, 1'b0, 14'h0, 1'b0);
    endtask

    initial begin
        #2 rst = 1'b0;
        checking = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);

        check_output("rst_in_rdy", 68'(in_rdy), 68'd1);
        check_output("rst_busy", 68'(busy), 68'd0);
        check_output("rst_u_A", u_A, 68'd0);
        check_output("rst_fflags", 68'(fflags), 68'd0);
        check_output("rst_cmp_vld", 68'(cmp_vld), 68'd0);

        // Single op: tag 0x05, completion 0x0011 four cycles later
        apply_stimulus(1'b1, 9'h005, 1'b0, 14'h0, 1'b0);
        check_output("single_u_en_active", 68'(u_en != 4'd0), 68'd1);
        idle(1);
        check_output("single_u_en_idle", 68'(u_en), 68'd0);
        idle(2);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0011, 1'b0);
        check_output("single_cmp_vld", 68'(cmp_vld), 68'd1);
        check_output("single_cmp_rob", 68'(cmp_rob), 68'h005);
        check_output("single_cmp_ret", 68'(cmp_ret), 68'h0011);
        check_output("single_fflags", 68'(fflags), 68'h11);
        idle(1);

        // Fill to capacity, then one completion reopens the input
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 9'(16 + i), 1'b0, 14'h0, 1'b0);
        check_output("full_in_rdy", 68'(in_rdy), 68'd0);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0100, 1'b0);
        check_output("full_in_rdy_after_pop", 68'(in_rdy), 68'd1);
        check_output("full_first_tag", 68'(cmp_rob), 68'h010);
        for (int i = 1; i < DEPTH; i++) apply_stimulus(1'b0, 9'h0, 1'b1, 14'(i << 5), 1'b0);
        check_output("full_last_tag", 68'(cmp_rob), 68'h017);
        idle(1);

        // Flush with coincident completion: two more returns drain, the third is orphaned
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 9'(32 + i), 1'b0, 14'h0, 1'b0);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0004, 1'b1);
        check_output("flush_cmp_vld", 68'(cmp_vld), 68'd0);
        check_output("flush_busy", 68'(busy), 68'd1);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0008, 1'b0);
        check_output("drain1_cmp_vld", 68'(cmp_vld), 68'd0);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0002, 1'b0);
        check_output("drain2_cmp_vld", 68'(cmp_vld), 68'd0);
        check_output("drain2_busy", 68'(busy), 68'd0);
        check_output("drain_fflags", 68'(fflags), 68'h11);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0001, 1'b0);
        check_output("orphan_set", 68'(err_orphan), 68'd1);
        idle(1);

        // Push and pop together for 20 cycles with 4 outstanding; pointers wrap
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 9'(64 + i), 1'b0, 14'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 9'(80 + i), 1'b1, 14'($urandom), 1'b0);
            if (i == 0) check_output("simul_first_tag", 68'(cmp_rob), 68'h040);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 9'h0, 1'b1, 14'($urandom), 1'b0);
        check_output("simul_last_tag", 68'(cmp_rob), 68'h063);
        check_output("simul_busy", 68'(busy), 68'd0);
        idle(1);

        // One op left outstanding long enough to trip the watchdog when it is built in
        apply_stimulus(1'b1, 9'h070, 1'b0, 14'h0, 1'b0);
        idle(260);
`ifdef FPSU_ISSUE_WDOG_EN
        check_output("wdog_tripped", 68'(wdog_err), 68'd1);
`else
        check_output("wdog_absent", 68'(wdog_err), 68'd0);
`endif
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h0, 1'b0);
        check_output("wdog_op_tag", 68'(cmp_rob), 68'h070);
        idle(1);

        // Reset pulse with 5 outstanding clears everything immediately
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 9'(112 + i), 1'b0, 14'h0, 1'b0);
        rst = 1'b0;
        #1;
        check_output("midrst_busy", 68'(busy), 68'd0);
        check_output("midrst_in_rdy", 68'(in_rdy), 68'd0);
        check_output("midrst_u_en", 68'(u_en), 68'd0);
        check_output("midrst_fflags", 68'(fflags), 68'd0);
        check_output("midrst_orphan", 68'(err_orphan), 68'd0);
        check_output("midrst_u_A", u_A, 68'd0);
        in_vld = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        check_output("postrst_busy", 68'(busy), 68'd0);
        apply_stimulus(1'b0, 9'h0, 1'b1, 14'h001F, 1'b0);
        check_output("postrst_orphan", 68'(err_orphan), 68'd1);
        check_output("postrst_cmp_vld", 68'(cmp_vld), 68'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
